// File: rtl/out_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// out_fifo_wr_arbiter
//
// Write-side scheduler for one OUT_FIFO. NREQ requesters share the FIFO's
// 10-lane x 8-bit write port. Arbitration is round-robin, and a requester can
// lock the grant for a burst of up to MAX_BURST words. The block throttles on
// the FIFO FULL/ALMOSTFULL flags and drives a registered WREN and D bus. All
// logic runs in the FIFO write-clock domain.
//
// Optional feature macro: OUT_FIFO_WR_ARB_STALL_CNT_EN
//   defined   : STALL_CNT counts cycles with a pending request but no space
//               (16-bit, saturating).
//   undefined : STALL_CNT is tied to zero and no counter is built.
//
// Parameters
//   NREQ       number of requesters, 2..8
//   MAX_BURST  maximum words per locked burst, 1..16
//
// Ports
//   CLK         in   write clock (same net as OUT_FIFO WRCLK)
//   RESET       in   asynchronous active-high reset
//   REQ         in   [NREQ]      per-requester word valid
//   LOCK        in   [NREQ]      requester asks to hold the grant for a burst
//   LAST        in   [NREQ]      final word of the requester's burst
//   DIN         in   [NREQ*80]   requester i word at [80i+79:80i]
//   GNT         out  [NREQ]      one-hot grant; REQ[i]&GNT[i] = word accepted
//   FULL        in   OUT_FIFO FULL flag
//   ALMOSTFULL  in   OUT_FIFO ALMOSTFULL flag (ALMOST_FULL_VALUE=2)
//   WREN        out  registered FIFO write enable
//   D           out  [80] registered FIFO data, lane k at [8k+7:8k]
//   OWNER       out  [3]  index of the current / last granted requester
//   BUSY        out  high while a locked burst is in progress
//   OVF_ERR     out  sticky: WREN was high while FULL was high
//   STALL_CNT   out  [16] stall counter (see macro above)
// -----------------------------------------------------------------------------
module out_fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ-1:0]      LOCK,
    input  logic [NREQ-1:0]      LAST,
    input  logic [NREQ*80-1:0]   DIN,
    output logic [NREQ-1:0]      GNT,
    input  logic                 FULL,
    input  logic                 ALMOSTFULL,
    output logic                 WREN,
    output logic [79:0]          D,
    output logic [2:0]           OWNER,
    output logic                 BUSY,
    output logic                 OVF_ERR,
    output logic [15:0]          STALL_CNT
);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [4:0]      MAX_CNT  = 5'(MAX_BURST);
    localparam bit              BURST_EN = (MAX_BURST > 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    // Index of the lowest set bit of a request vector.
    function automatic logic [2:0] first_idx(input logic [NREQ-1:0] vec);
        logic [2:0] idx;
        logic       found;
        idx   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && vec[i]) begin
                idx   = 3'(i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return idx;
    endfunction

    // Round-robin successor, wrapping NREQ-1 back to 0.
    function automatic logic [2:0] next_idx(input logic [2:0] i);
        return (i == 3'(NREQ - 1)) ? 3'd0 : (i + 3'd1);
    endfunction

    state_t            state_r;
    logic [2:0]        ptr_r;
    logic [2:0]        owner_r;
    logic [NREQ-1:0]   owner_oh_r;
    logic [4:0]        cnt_r;
    logic              wren_r;
    logic [79:0]       d_r;
    logic              busy_r;
    logic              ovf_r;

    logic              space_s;
    logic [NREQ-1:0]   mask_s;
    logic [NREQ-1:0]   req_hi_s;
    logic [NREQ-1:0]   gnt_s;
    logic [2:0]        win_s;
    logic              accept_s;
    logic              lock_s;
    logic              last_s;
    logic [79:0]       win_data_s;

    assign space_s = !FULL && !ALMOSTFULL;

    // Grant selection: owner-only during a burst, otherwise first request at
    // or after the round-robin pointer (requests above the pointer first,
    // then wrap to the bottom of the vector).
    always_comb begin
        mask_s   = '0;
        req_hi_s = '0;
        gnt_s    = '0;
        win_s    = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            mask_s[i] = (3'(i) >= ptr_r);
        end
        req_hi_s = REQ & mask_s;
        if (RESET || !space_s) begin
            gnt_s = '0;
            win_s = 3'd0;
        end else if (state_r == ST_BURST) begin
            gnt_s = REQ & owner_oh_r;
            win_s = owner_r;
        end else if (|req_hi_s) begin
            win_s = first_idx(req_hi_s);
            gnt_s = ONE_HOT0 << win_s;
        end else if (|REQ) begin
            win_s = first_idx(REQ);
            gnt_s = ONE_HOT0 << win_s;
        end else begin
            gnt_s = '0;
            win_s = 3'd0;
        end
    end

    // Winner's data word; grant is one-hot so a simple OR-mux suffices.
    always_comb begin
        win_data_s = 80'h0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_s[i]) begin
                win_data_s = DIN[i*80 +: 80];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // Grants are only issued to requesting lanes, so any grant is an accept.
    assign accept_s = |gnt_s;
    assign lock_s   = |(LOCK & gnt_s);
    assign last_s   = |(LAST & gnt_s);

    // Arbiter FSM, write pipeline register and sticky overflow flag.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r    <= ST_ARB;
            ptr_r      <= 3'd0;
            owner_r    <= 3'd0;
            owner_oh_r <= '0;
            cnt_r      <= 5'd0;
            wren_r     <= 1'b0;
            d_r        <= 80'h0;
            busy_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            wren_r <= accept_s;
            if (accept_s) begin
                d_r <= win_data_s;
            end else begin
                d_r <= d_r;
            end
            if (wren_r && FULL) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end
            case (state_r)
                ST_ARB: begin
                    if (accept_s) begin
                        owner_r    <= win_s;
                        owner_oh_r <= gnt_s;
                        if (BURST_EN && lock_s && !last_s) begin
                            state_r <= ST_BURST;
                            busy_r  <= 1'b1;
                            cnt_r   <= 5'd1;
                        end else begin
                            ptr_r <= next_idx(win_s);
                        end
                    end else begin
                        state_r <= ST_ARB;
                    end
                end
                ST_BURST: begin
                    // LAST and hitting the burst limit together still give a
                    // single exit with one pointer advance.
                    if (accept_s) begin
                        if (last_s || ((cnt_r + 5'd1) >= MAX_CNT)) begin
                            state_r <= ST_ARB;
                            busy_r  <= 1'b0;
                            cnt_r   <= 5'd0;
                            ptr_r   <= next_idx(owner_r);
                        end else begin
                            cnt_r <= cnt_r + 5'd1;
                        end
                    end else begin
                        state_r <= ST_BURST;
                    end
                end
                default: begin
                    state_r <= ST_ARB;
                    busy_r  <= 1'b0;
                    cnt_r   <= 5'd0;
                end
            endcase
        end
    end

`ifdef OUT_FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0] stall_r;

    // Saturating count of cycles where someone wants to write but cannot.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_r <= 16'h0000;
        end else if (|REQ && !space_s && (stall_r != 16'hFFFF)) begin
            stall_r <= stall_r + 16'h0001;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign STALL_CNT = stall_r;
`else
    assign STALL_CNT = 16'h0000;
`endif

    assign GNT     = gnt_s;
    assign WREN    = wren_r;
    assign D       = d_r;
    assign OWNER   = owner_r;
    assign BUSY    = busy_r;
    assign OVF_ERR = ovf_r;

endmodule

// File: tb/tb_out_fifo_wr_arbiter.sv
// Self-checking bench for out_fifo_wr_arbiter (NREQ=4, MAX_BURST=8).
// A behavioural model tracks who should win each cycle and what the FIFO
// write port must show one cycle later; a negedge process compares the DUT
// against it, and directed scenarios add literal expectations.
module tb_out_fifo_wr_arbiter;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 8;

    logic                CLK = 1'b0;
    logic                RESET;
    logic [NREQ-1:0]     REQ, LOCK, LAST;
    logic [NREQ*80-1:0]  DIN;
    logic [NREQ-1:0]     GNT;
    logic                FULL, ALMOSTFULL;
    logic                WREN;
    logic [79:0]         D;
    logic [2:0]          OWNER;
    logic                BUSY, OVF_ERR;
    logic [15:0]         STALL_CNT;

    out_fifo_wr_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .LOCK(LOCK), .LAST(LAST),
        .DIN(DIN), .GNT(GNT), .FULL(FULL), .ALMOSTFULL(ALMOSTFULL),
        .WREN(WREN), .D(D), .OWNER(OWNER), .BUSY(BUSY), .OVF_ERR(OVF_ERR),
        .STALL_CNT(STALL_CNT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy;
    int          m_owner, m_cnt, m_ptr;
    bit          m_wren, m_ovf;
    logic [79:0] m_d;
    int          m_stall;
    int          glog[$];

    always @(negedge CLK) begin
        int  win;
        bit  space;
        logic [NREQ-1:0] exp_g;
        win   = -1;
        space = !FULL && !ALMOSTFULL;
        if (RESET) begin
            m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
            m_wren = 0; m_ovf = 0; m_d = '0; m_stall = 0;
        end else if (space) begin
            if (m_busy) begin
                if (REQ[m_owner]) win = m_owner;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    int j;
                    j = (m_ptr + k) % NREQ;
                    if (win < 0 && REQ[j]) win = j;
                end
            end
        end
        exp_g = (win >= 0) ? NREQ'(1 << win) : '0;
        chk("GNT", 80'(GNT), 80'(exp_g));
        chk("WREN", 80'(WREN), 80'(m_wren));
        chk("D", D, m_d);
        chk("OWNER", 80'(OWNER), 80'(m_owner));
        chk("BUSY", 80'(BUSY), 80'(m_busy));
        chk("OVF_ERR", 80'(OVF_ERR), 80'(m_ovf));
        chk("STALL_CNT", 80'(STALL_CNT), 80'(m_stall));
        if (!RESET) begin
            if (m_wren && FULL) m_ovf = 1;
`ifdef OUT_FIFO_WR_ARB_STALL_CNT_EN
            if ((|REQ) && !space && m_stall < 65535) m_stall++;
`endif
            m_wren = (win >= 0);
            if (win >= 0) begin
                m_d = DIN[win*80 +: 80];
                glog.push_back(win);
                if (!m_busy) begin
                    m_owner = win;
                    if (LOCK[win] && !LAST[win] && MAX_BURST > 1) begin
                        m_busy = 1; m_cnt = 1;
                    end else begin
                        m_ptr = (win + 1) % NREQ;
                    end
                end else begin
                    m_cnt++;
                    if (LAST[win] || m_cnt == MAX_BURST) begin
                        m_busy = 0; m_cnt = 0;
                        m_ptr = (m_owner + 1) % NREQ;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // One cycle of directed inputs, applied 2 time units after the rising edge.
    task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                         input logic [3:0] last, input logic full, input logic af);
        @(posedge CLK);
        #2;
        RESET = rst; REQ = req; LOCK = lock; LAST = last;
        FULL = full; ALMOSTFULL = af;
        for (int i = 0; i < NREQ; i++) DIN[i*80 +: 80] = {16'($urandom), $urandom, $urandom};
    endtask

    initial begin
        int g_cnt;
        RESET = 1'b1; REQ = '0; LOCK = '0; LAST = '0; FULL = 1'b0; ALMOSTFULL = 1'b0; DIN = '0;
        drive(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        drive(1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
        #1;
        chk("reset_gnt", 80'(GNT), 80'h0);
        chk("reset_wren", 80'(WREN), 80'h0);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);

        // 1: plain round robin
        glog.delete();
        repeat (5) drive(0, 4'b1111, 4'b0000, 4'b0000, 0, 0);
        #4;
        chk("rr_len", 80'(glog.size()), 80'd5);
        if (glog.size() == 5) begin
            chk("rr_g0", 80'(glog[0]), 80'd0);
            chk("rr_g1", 80'(glog[1]), 80'd1);
            chk("rr_g2", 80'(glog[2]), 80'd2);
            chk("rr_g3", 80'(glog[3]), 80'd3);
            chk("rr_g4", 80'(glog[4]), 80'd0);
        end
        chk("rr_wren", 80'(WREN), 80'd1);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);

        // 2: locked burst of 5 on requester 2, LAST on word 5
        for (int w = 1; w <= 5; w++) begin
            drive(0, 4'b0101, 4'b0100, (w == 5) ? 4'b0100 : 4'b0000, 0, 0);
            #4;
            chk("burst2_gnt", 80'(GNT), 80'(4'b0100));
            chk("burst2_busy", 80'(BUSY), (w == 1) ? 80'd0 : 80'd1);
        end
        drive(0, 4'b0001, 4'b0000, 4'b0000, 0, 0);
        #4;
        chk("burst2_after", 80'(GNT), 80'(4'b0001));
        chk("burst2_busy_end", 80'(BUSY), 80'd0);

        // 3: LOCK without LAST is cut at MAX_BURST, pointer then = 2
        g_cnt = 0;
        for (int w = 1; w <= MAX_BURST; w++) begin
            drive(0, 4'b0010, 4'b0010, 4'b0000, 0, 0);
            #4;
            if (GNT == 4'b0010) g_cnt++;
        end
        chk("burst3_count", 80'(g_cnt), 80'd8);
        drive(0, 4'b0011, 4'b0000, 4'b0000, 0, 0);
        #4;
        chk("burst3_ptr", 80'(GNT), 80'(4'b0001));
        chk("burst3_busy", 80'(BUSY), 80'd0);

        // 4: ALMOSTFULL throttle for 3 cycles
        for (int w = 0; w < 3; w++) begin
            drive(0, 4'b0001, 4'b0000, 4'b0000, 0, 1);
            #4;
            chk("af_gnt", 80'(GNT), 80'h0);
        end
        drive(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        #4;
`ifdef OUT_FIFO_WR_ARB_STALL_CNT_EN
        chk("af_stall", 80'(STALL_CNT), 80'd3);
`else
        chk("af_stall", 80'(STALL_CNT), 80'd0);
`endif
        chk("af_ovf", 80'(OVF_ERR), 80'd0);

        // 5: FULL while WREN is high -> sticky OVF_ERR
        drive(0, 4'b0001, 4'b0000, 4'b0000, 0, 0);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
        #4;
        chk("ovf_pre", 80'(OVF_ERR), 80'd0);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        #4;
        chk("ovf_set", 80'(OVF_ERR), 80'd1);
        repeat (3) drive(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        #4;
        chk("ovf_sticky", 80'(OVF_ERR), 80'd1);

        // 6: RESET mid-burst at cnt=3
        repeat (3) drive(0, 4'b1001, 4'b1000, 4'b0000, 0, 0);
        #4;
        chk("rst6_busy_pre", 80'(BUSY), 80'd1);
        drive(1, 4'b1001, 4'b1000, 4'b0000, 0, 0);
        #1;
        chk("rst6_wren", 80'(WREN), 80'd0);
        chk("rst6_busy", 80'(BUSY), 80'd0);
        chk("rst6_gnt", 80'(GNT), 80'h0);
        chk("rst6_owner", 80'(OWNER), 80'd0);
        chk("rst6_ovf", 80'(OVF_ERR), 80'd0);
        chk("rst6_d", D, 80'h0);
        drive(0, 4'b1001, 4'b0000, 4'b0000, 0, 0);
        #4;
        chk("rst6_next", 80'(GNT), 80'(4'b0001));
        repeat (3) drive(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
